packet_forwarder: RTL and testbench

Ingress stage of the packet filter IP. Accepts the AXI-Stream packet input, assigns each packet a wrap-around reorder tag, selects a free filter core, and broadcasts every beat to that core and to the circular buffer through a registered one-entry fork. It limits outstanding tags to the buffer depth, so tag order always matches buffer slot order.

---
 rtl/pf_pkg.sv | 23 ++
 rtl/axis_fork_reg.sv | 85 ++++++++
 rtl/packet_forwarder.sv | 166 ++++++++++++++++
 tb/tb_packet_forwarder.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pf_pkg.sv
// Shared definitions for the packet filter ingress path: default sizes,
// the ingress FSM state type and the reorder-tag wrap helper.
package pf_pkg;

    localparam int PF_DATA_WIDTH = 64;
    localparam int PF_TAG_WIDTH  = 6;
    localparam int PF_CBUF_SIZE  = 50;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } pf_state_e;

    // Next reorder tag; wraps modulus-1 -> 0. 32-bit so callers of any
    // tag width can use it with an explicit cast.
    function automatic logic [31:0] tag_inc(input logic [31:0] tag, input logic [31:0] modulus);
        if (tag >= modulus - 32'd1) begin
            return 32'd0;
        end
        return tag + 32'd1;
    endfunction

endpackage

// File: rtl/axis_fork_reg.sv
// One-entry broadcast register feeding two consumers (buffer and core).
// Handshake: a side transfers on a cycle where its valid (pend_*_o) and its
// ready are both high; valid never depends on ready. The entry is reloaded
// only when both sides have taken it or take it this cycle (can_load_o).
module axis_fork_reg #(
    parameter int DATA_WIDTH = 64,
    parameter int KEEP_WIDTH = 8,
    parameter int TAG_WIDTH  = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic [KEEP_WIDTH-1:0] keep_i,
    input  logic                  last_i,
    input  logic [TAG_WIDTH-1:0]  tag_i,
    input  logic                  buf_ready_i,
    input  logic                  core_ready_i,
    output logic                  pend_buf_o,
    output logic                  pend_core_o,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic [KEEP_WIDTH-1:0] keep_o,
    output logic                  last_o,
    output logic [TAG_WIDTH-1:0]  tag_o,
    output logic                  can_load_o,
    output logic                  drain_o
);

    logic                  pend_buf_q, pend_buf_d;
    logic                  pend_core_q, pend_core_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [KEEP_WIDTH-1:0] keep_q, keep_d;
    logic                  last_q, last_d;
    logic [TAG_WIDTH-1:0]  tag_q, tag_d;
    logic                  all_clear;

    assign all_clear  = (!pend_buf_q || buf_ready_i) && (!pend_core_q || core_ready_i);
    assign can_load_o = all_clear;
    assign drain_o    = (pend_buf_q || pend_core_q) && all_clear;

    // Next entry: a load refills both flags, otherwise each flag drops on its own handshake.
    always_comb begin
        pend_buf_d  = pend_buf_q && !buf_ready_i;
        pend_core_d = pend_core_q && !core_ready_i;
        data_d      = data_q;
        keep_d      = keep_q;
        last_d      = last_q;
        tag_d       = tag_q;
        if (load_i) begin
            pend_buf_d  = 1'b1;
            pend_core_d = 1'b1;
            data_d      = data_i;
            keep_d      = keep_i;
            last_d      = last_i;
            tag_d       = tag_i;
        end
    end

    // Entry storage; reset empties the slot and zeroes its contents.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_buf_q  <= 1'b0;
            pend_core_q <= 1'b0;
            data_q      <= '0;
            keep_q      <= '0;
            last_q      <= 1'b0;
            tag_q       <= '0;
        end else begin
            pend_buf_q  <= pend_buf_d;
            pend_core_q <= pend_core_d;
            data_q      <= data_d;
            keep_q      <= keep_d;
            last_q      <= last_d;
            tag_q       <= tag_d;
        end
    end

    assign pend_buf_o  = pend_buf_q;
    assign pend_core_o = pend_core_q;
    assign data_o      = data_q;
    assign keep_o      = keep_q;
    assign last_o      = last_q;
    assign tag_o       = tag_q;

endmodule

// File: rtl/packet_forwarder.sv
// Ingress stage: tags each packet, picks the lowest free filter core, and
// broadcasts beats to that core and the circular buffer through a fork
// register. Outstanding tags are capped at the buffer depth.
module packet_forwarder
    import pf_pkg::*;
#(
    parameter int N_CORES              = 4,
    parameter int TAG_WIDTH            = PF_TAG_WIDTH,
    parameter int CIRCULAR_BUFFER_SIZE = PF_CBUF_SIZE,
    parameter int DATA_WIDTH           = PF_DATA_WIDTH,
    localparam int KEEP_WIDTH          = DATA_WIDTH / 8,
    localparam int SEL_W               = (N_CORES > 1) ? $clog2(N_CORES) : 1,
    localparam int CNT_W               = $clog2(CIRCULAR_BUFFER_SIZE + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] s_TDATA,
    input  logic [KEEP_WIDTH-1:0] s_TKEEP,
    input  logic                  s_TLAST,
    input  logic                  s_TVALID,
    output logic                  s_TREADY,
    output logic [DATA_WIDTH-1:0] buf_TDATA,
    output logic [KEEP_WIDTH-1:0] buf_TKEEP,
    output logic                  buf_TLAST,
    output logic [TAG_WIDTH-1:0]  buf_reorder_tag,
    output logic                  buf_TVALID,
    input  logic                  buf_TREADY,
    output logic [DATA_WIDTH-1:0] core_TDATA,
    output logic                  core_TLAST,
    output logic [TAG_WIDTH-1:0]  core_reorder_tag,
    output logic [N_CORES-1:0]    core_TVALID,
    input  logic [N_CORES-1:0]    core_TREADY,
    input  logic [N_CORES-1:0]    core_done,
    input  logic                  tag_retire,
    output pf_state_e             dbg_state_o,
    output logic [N_CORES-1:0]    dbg_busy_o,
    output logic [CNT_W-1:0]      dbg_outstanding_o
);

    localparam logic [CNT_W-1:0] CREDIT_MAX = CNT_W'(CIRCULAR_BUFFER_SIZE);

    pf_state_e             state_q;
    logic [SEL_W-1:0]      sel_q;
    logic [N_CORES-1:0]    busy_q, busy_d;
    logic [CNT_W-1:0]      outstanding_q, outstanding_d;
    logic [TAG_WIDTH-1:0]  next_tag_q, next_tag_d;
    logic                  last_in_q;

    logic [SEL_W-1:0]      free_idx;
    logic                  start, beat_acc, pkt_end, retire_ok;
    logic                  pend_buf, pend_core, fork_can_load, fork_drain;
    logic [DATA_WIDTH-1:0] fork_data;
    logic                  fork_last;
    logic [TAG_WIDTH-1:0]  fork_tag;

    // Lowest-index core that is not busy.
    always_comb begin
        free_idx = '0;
        for (int i = N_CORES - 1; i >= 0; i--) begin
            if (!busy_q[i]) begin
                free_idx = SEL_W'(i);
            end
        end
    end

    assign start = (state_q == IDLE) && s_TVALID && !pend_buf && !pend_core
                   && (|(~busy_q)) && (outstanding_q < CREDIT_MAX);

    // Ingress stops once the packet's TLAST is in, until the FSM rearms in IDLE.
    assign s_TREADY  = (state_q == STREAM) && !last_in_q && fork_can_load;
    assign beat_acc  = s_TVALID && s_TREADY;
    assign pkt_end   = (state_q == STREAM) && fork_drain && fork_last;
    assign retire_ok = tag_retire && (outstanding_q != '0);

    // Busy set wins over a same-cycle done; credits net out when start and retire coincide.
    always_comb begin
        busy_d = busy_q & ~core_done;
        if (start) begin
            busy_d = busy_d | (N_CORES'(1) << free_idx);
        end
        outstanding_d = outstanding_q;
        if (start && !retire_ok) begin
            outstanding_d = outstanding_q + CNT_W'(1);
        end else if (!start && retire_ok) begin
            outstanding_d = outstanding_q - CNT_W'(1);
        end
        next_tag_d = TAG_WIDTH'(tag_inc(32'(next_tag_q), 32'(CIRCULAR_BUFFER_SIZE)));
    end

    // Packet FSM with core selection, busy map, credit count and tag counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            sel_q         <= '0;
            busy_q        <= '0;
            outstanding_q <= '0;
            next_tag_q    <= '0;
            last_in_q     <= 1'b0;
        end else begin
            busy_q        <= busy_d;
            outstanding_q <= outstanding_d;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        sel_q     <= free_idx;
                        last_in_q <= 1'b0;
                        state_q   <= STREAM;
                    end
                end
                STREAM: begin
                    if (beat_acc && s_TLAST) begin
                        last_in_q <= 1'b1;
                    end
                    if (pkt_end) begin
                        state_q    <= IDLE;
                        next_tag_q <= next_tag_d;
                        last_in_q  <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    axis_fork_reg #(
        .DATA_WIDTH (DATA_WIDTH),
        .KEEP_WIDTH (KEEP_WIDTH),
        .TAG_WIDTH  (TAG_WIDTH)
    ) u_fork (
        .clk          (clk),
        .rst_n        (rst_n),
        .load_i       (beat_acc),
        .data_i       (s_TDATA),
        .keep_i       (s_TKEEP),
        .last_i       (s_TLAST),
        .tag_i        (next_tag_q),
        .buf_ready_i  (buf_TREADY),
        .core_ready_i (core_TREADY[sel_q]),
        .pend_buf_o   (pend_buf),
        .pend_core_o  (pend_core),
        .data_o       (fork_data),
        .keep_o       (buf_TKEEP),
        .last_o       (fork_last),
        .tag_o        (fork_tag),
        .can_load_o   (fork_can_load),
        .drain_o      (fork_drain)
    );

    // Only the selected core sees a valid; the data bus is shared.
    always_comb begin
        core_TVALID        = '0;
        core_TVALID[sel_q] = pend_core;
    end

    assign buf_TVALID        = pend_buf;
    assign buf_TDATA         = fork_data;
    assign buf_TLAST         = fork_last;
    assign buf_reorder_tag   = fork_tag;
    assign core_TDATA        = fork_data;
    assign core_TLAST        = fork_last;
    assign core_reorder_tag  = fork_tag;
    assign dbg_state_o       = state_q;
    assign dbg_busy_o        = busy_q;
    assign dbg_outstanding_o = outstanding_q;

endmodule

// File: tb/tb_packet_forwarder.sv
// Bench for packet_forwarder: table of packets with expected core, tag,
// busy map and credit count, plus hand-written multi-cycle sequences.
module tb_packet_forwarder;
  import pf_pkg::*;

  localparam int NC  = 4;
  localparam int TW  = 6;
  localparam int CBS = 50;
  localparam int DW  = 64;
  localparam int KW  = DW / 8;
  localparam int BW  = TW + 1 + KW + DW;
  localparam int CW  = 2 + TW + 1 + DW;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [DW-1:0] s_TDATA;
  logic [KW-1:0] s_TKEEP;
  logic          s_TLAST, s_TVALID, s_TREADY;
  logic [DW-1:0] buf_TDATA;
  logic [KW-1:0] buf_TKEEP;
  logic          buf_TLAST, buf_TVALID, buf_TREADY;
  logic [TW-1:0] buf_reorder_tag, core_reorder_tag;
  logic [DW-1:0] core_TDATA;
  logic          core_TLAST;
  logic [NC-1:0] core_TVALID, core_TREADY, core_done;
  logic          tag_retire;
  pf_state_e     dbg_state;
  logic [NC-1:0] dbg_busy;
  logic [5:0]    dbg_out;

  packet_forwarder #(
    .N_CORES(NC), .TAG_WIDTH(TW), .CIRCULAR_BUFFER_SIZE(CBS), .DATA_WIDTH(DW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .s_TDATA(s_TDATA), .s_TKEEP(s_TKEEP), .s_TLAST(s_TLAST),
    .s_TVALID(s_TVALID), .s_TREADY(s_TREADY),
    .buf_TDATA(buf_TDATA), .buf_TKEEP(buf_TKEEP), .buf_TLAST(buf_TLAST),
    .buf_reorder_tag(buf_reorder_tag), .buf_TVALID(buf_TVALID), .buf_TREADY(buf_TREADY),
    .core_TDATA(core_TDATA), .core_TLAST(core_TLAST), .core_reorder_tag(core_reorder_tag),
    .core_TVALID(core_TVALID), .core_TREADY(core_TREADY), .core_done(core_done),
    .tag_retire(tag_retire),
    .dbg_state_o(dbg_state), .dbg_busy_o(dbg_busy), .dbg_outstanding_o(dbg_out)
  );

  // ---------------- scoreboard state ----------------
  logic [BW-1:0] exp_q[$];
  logic [CW-1:0] exp_core_q[$];
  int n_checks;
  int n_errors;
  int n_buf_hs;
  int n_core_hs;

  typedef struct {
    int           nb;
    logic [DW-1:0] base;
    logic [NC-1:0] done_before;
    int           retire_before;
    logic [NC-1:0] done_at;
    logic         retire_at;
    int           exp_core;
    logic [TW-1:0] exp_tag;
    logic [NC-1:0] exp_busy;
    int           exp_out;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: timed out waiting (t=%0t)", name, $time);
  endtask

  // ---------------- driver tasks ----------------
  task automatic push_exp(input int core, input logic [TW-1:0] tag, input logic last,
                          input logic [KW-1:0] keep, input logic [DW-1:0] data);
    exp_q.push_back({tag, last, keep, data});
    exp_core_q.push_back({2'(core), tag, last, data});
  endtask

  // Present one beat and hold it until accepted; returns at posedge+1.
  task automatic drive_beat(input logic [DW-1:0] data, input logic [KW-1:0] keep, input logic last);
    int cnt;
    s_TDATA  = data;
    s_TKEEP  = keep;
    s_TLAST  = last;
    s_TVALID = 1'b1;
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (!s_TREADY && cnt < 300);
    if (!s_TREADY) timeout("beat_accept");
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [NC-1:0] done, input logic retire);
    core_done  = done;
    tag_retire = retire;
    @(posedge clk);
    #1;
    core_done  = '0;
    tag_retire = 1'b0;
  endtask

  task automatic wait_idle();
    int cnt;
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (dbg_state != IDLE && cnt < 500);
    if (dbg_state != IDLE) timeout("wait_idle");
    @(posedge clk);
    #1;
  endtask

  // Full packet; done_at/retire_at land in the cycle the FSM starts it.
  task automatic send_pkt(input int nb, input logic [DW-1:0] base, input int core,
                          input logic [TW-1:0] tag, input logic [NC-1:0] done_at,
                          input logic retire_at);
    for (int b = 0; b < nb; b++)
      push_exp(core, tag, (b == nb - 1), (b == nb - 1) ? 8'h0F : 8'hFF, base + DW'(b));
    s_TDATA  = base;
    s_TKEEP  = (nb == 1) ? 8'h0F : 8'hFF;
    s_TLAST  = (nb == 1);
    s_TVALID = 1'b1;
    pulse(done_at, retire_at);
    for (int b = 0; b < nb; b++)
      drive_beat(base + DW'(b), (b == nb - 1) ? 8'h0F : 8'hFF, (b == nb - 1));
    s_TVALID = 1'b0;
    s_TLAST  = 1'b0;
  endtask

  // Packet that must stay blocked in IDLE until the given pulse frees it.
  task automatic send_blocked(input logic [DW-1:0] base, input int core, input logic [TW-1:0] tag,
                              input logic [NC-1:0] rel_done, input logic rel_retire,
                              input string name);
    logic ok;
    push_exp(core, tag, 1'b1, 8'h0F, base);
    s_TDATA  = base;
    s_TKEEP  = 8'h0F;
    s_TLAST  = 1'b1;
    s_TVALID = 1'b1;
    ok = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (s_TREADY || dbg_state != IDLE) ok = 1'b0;
    end
    check(name, ok, 1'b1);
    @(posedge clk);
    #1;
    pulse(rel_done, rel_retire);
    drive_beat(base, 8'h0F, 1'b1);
    s_TVALID = 1'b0;
    s_TLAST  = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [DW-1:0] got_b;
    int hs_b0, hs_c0, cnt;

    n_checks = 0; n_errors = 0; n_buf_hs = 0; n_core_hs = 0;
    s_TDATA = '0; s_TKEEP = '0; s_TLAST = 1'b0; s_TVALID = 1'b0;
    buf_TREADY = 1'b1; core_TREADY = '1; core_done = '0; tag_retire = 1'b0;

    //            nb base      done_b  rb done_at ret core tag busy     out
    vecs[0] = '{3, 64'h1000, 4'b0000, 0, 4'b0000, 1'b0, 0, 6'd0, 4'b0001, 1};
    vecs[1] = '{1, 64'h2000, 4'b0000, 0, 4'b0000, 1'b0, 1, 6'd1, 4'b0011, 2};
    vecs[2] = '{2, 64'h3000, 4'b0000, 0, 4'b0000, 1'b0, 2, 6'd2, 4'b0111, 3};
    vecs[3] = '{4, 64'h4000, 4'b0000, 0, 4'b0000, 1'b0, 3, 6'd3, 4'b1111, 4};
    vecs[4] = '{2, 64'h6000, 4'b0001, 0, 4'b0001, 1'b1, 0, 6'd5, 4'b1111, 5};
    vecs[5] = '{2, 64'h7000, 4'b1111, 2, 4'b0000, 1'b0, 0, 6'd6, 4'b0001, 4};

    // Scoreboard monitor: handshakes are decided by values stable at the negedge.
    fork
      forever begin
        @(negedge clk);
        if (rst_n) begin
          if (buf_TVALID && buf_TREADY) begin
            n_buf_hs++;
            if (exp_q.size() == 0) check("buf_unexpected_beat", {buf_reorder_tag, buf_TLAST, buf_TKEEP, buf_TDATA}, '0);
            else check("buf_beat", {buf_reorder_tag, buf_TLAST, buf_TKEEP, buf_TDATA}, exp_q.pop_front());
          end
          if (core_TVALID != '0) check("core_valid_onehot", $onehot0(core_TVALID), 1'b1);
          for (int i = 0; i < NC; i++) begin
            if (core_TVALID[i] && core_TREADY[i]) begin
              n_core_hs++;
              if (exp_core_q.size() == 0) check("core_unexpected_beat", {2'(i), core_reorder_tag, core_TLAST, core_TDATA}, '0);
              else check("core_beat", {2'(i), core_reorder_tag, core_TLAST, core_TDATA}, exp_core_q.pop_front());
            end
          end
        end
      end
    join_none

    // Reset state
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_s_TREADY", s_TREADY, 1'b0);
    check("rst_buf_TVALID", buf_TVALID, 1'b0);
    check("rst_core_TVALID", core_TVALID, 4'b0);
    check("rst_buf_tag", buf_reorder_tag, 6'd0);
    check("rst_busy", dbg_busy, 4'b0);
    check("rst_outstanding", dbg_out, 6'd0);
    check("rst_state", dbg_state, IDLE);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Latency: first beat accepted, visible on both sides one cycle later
    for (int v = 0; v < 4; v++) begin
      send_pkt(vecs[v].nb, vecs[v].base, vecs[v].exp_core, vecs[v].exp_tag,
               vecs[v].done_at, vecs[v].retire_at);
      wait_idle();
      check($sformatf("vec%0d_busy", v), dbg_busy, vecs[v].exp_busy);
      check($sformatf("vec%0d_outstanding", v), dbg_out, 6'(vecs[v].exp_out));
    end

    // Core exhaustion: 5th packet waits until core 2 reports done
    send_blocked(64'h5000, 2, 6'd4, 4'b0100, 1'b0, "all_cores_busy_blocks");
    wait_idle();
    check("exhaust_busy", dbg_busy, 4'b1111);
    check("exhaust_outstanding", dbg_out, 6'd5);

    // Simultaneous events and credit release
    for (int v = 4; v < 6; v++) begin
      if (vecs[v].done_before != '0) pulse(vecs[v].done_before, 1'b0);
      for (int r = 0; r < vecs[v].retire_before; r++) pulse('0, 1'b1);
      send_pkt(vecs[v].nb, vecs[v].base, vecs[v].exp_core, vecs[v].exp_tag,
               vecs[v].done_at, vecs[v].retire_at);
      wait_idle();
      check($sformatf("vec%0d_busy", v), dbg_busy, vecs[v].exp_busy);
      check($sformatf("vec%0d_outstanding", v), dbg_out, 6'(vecs[v].exp_out));
    end

    // Fork stall: buffer side held off for 4 cycles on beat 2
    hs_b0 = n_buf_hs;
    hs_c0 = n_core_hs;
    fork
      send_pkt(4, 64'h8000, 1, 6'd7, '0, 1'b0);
      begin
        cnt = 0;
        do begin
          @(posedge clk);
          #1;
          cnt++;
        end while (!(buf_TVALID && buf_TDATA == 64'h8001) && cnt < 100);
        if (cnt >= 100) timeout("stall_find_beat2");
        buf_TREADY = 1'b0;
        for (int k = 0; k < 4; k++) begin
          @(negedge clk);
          check("stall_s_TREADY_low", s_TREADY, 1'b0);
          check("stall_buf_holds", buf_TVALID, 1'b1);
          if (k > 0) check("stall_core_taken_once", core_TVALID, 4'b0);
        end
        @(posedge clk);
        #1;
        buf_TREADY = 1'b1;
      end
    join
    wait_idle();
    check("stall_buf_beats", n_buf_hs - hs_b0, 4);
    check("stall_core_beats", n_core_hs - hs_c0, 4);
    check("stall_busy", dbg_busy, 4'b0011);
    check("stall_outstanding", dbg_out, 6'd5);

    // Mid-packet reset: beat 2 is sitting in the fork when reset hits
    push_exp(2, 6'd8, 1'b0, 8'hFF, 64'h9000);
    s_TDATA = 64'h9000; s_TKEEP = 8'hFF; s_TLAST = 1'b0; s_TVALID = 1'b1;
    drive_beat(64'h9000, 8'hFF, 1'b0);
    drive_beat(64'h9001, 8'hFF, 1'b0);
    check("pre_reset_beat2_loaded", buf_TDATA, 64'h9001);
    #2;
    rst_n = 1'b0;
    s_TVALID = 1'b0;
    #1;
    check("midrst_buf_TVALID", buf_TVALID, 1'b0);
    check("midrst_core_TVALID", core_TVALID, 4'b0);
    check("midrst_s_TREADY", s_TREADY, 1'b0);
    check("midrst_buf_TLAST", buf_TLAST, 1'b0);
    got_b = buf_TDATA;
    check("midrst_buf_TDATA", got_b, '0);
    check("midrst_busy", dbg_busy, 4'b0);
    check("midrst_outstanding", dbg_out, 6'd0);
    check("midrst_state", dbg_state, IDLE);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Tag wrap and credits: 50 packets, every one on core 0 with tags 0..49
    for (int i = 0; i < CBS; i++) begin
      if (i > 0) pulse(4'b0001, 1'b0);
      send_pkt(1, 64'hA000 + DW'(i), 0, 6'(i), '0, 1'b0);
      wait_idle();
    end
    check("credits_full", dbg_out, 6'd50);
    pulse(4'b0001, 1'b0);
    send_blocked(64'hB000, 0, 6'd0, 4'b0000, 1'b1, "credit_limit_blocks");
    wait_idle();
    check("wrap_outstanding", dbg_out, 6'd50);
    check("wrap_busy", dbg_busy, 4'b0001);

    // Final report
    repeat (3) @(posedge clk);
    check("buf_queue_drained", exp_q.size(), 0);
    check("core_queue_drained", exp_core_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
